// File: rtl/apb2_master_pkg.sv
// apb2_master_pkg
// Shared definitions for the APB2 initiator slice:
//   - APB transfer phase encoding used by the master FSM
//   - default bus widths and command-buffer depth
//   - command entry layout {write, addr, wdata} and its width helper
package apb2_master_pkg;

  localparam int DEF_ADDR_BITS  = 6;
  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // A buffered command is packed MSB-first as {write, addr, wdata}.
  function automatic int cmd_entry_bits(input int addr_bits, input int data_bits);
    return 1 + addr_bits + data_bits;
  endfunction

endpackage

// File: rtl/apb2_master_if.sv
// apb2_master_if
// Bundles the command port, the response port and the APB2 bus of the initiator.
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata : command handshake (to master)
//   rsp_valid/rsp_write/rsp_rdata                    : completion report (from master)
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA                 : APB2 request (from master)
//   PRDATA                                           : APB2 read data (to master)
// Modport master is the initiator view; modport slave is the environment view
// (command source, response sink and APB target together).
interface apb2_master_if
  import apb2_master_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS
);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [ADDR_BITS-1:0] cmd_addr;
  logic [DATA_BITS-1:0] cmd_wdata;

  logic                 rsp_valid;
  logic                 rsp_write;
  logic [DATA_BITS-1:0] rsp_rdata;

  logic [ADDR_BITS-1:0] PADDR;
  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [DATA_BITS-1:0] PWDATA;
  logic [DATA_BITS-1:0] PRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

endinterface

// File: rtl/apb2_master_cmd_fifo.sv
// apb2_cmd_fifo
// Synchronous show-ahead FIFO holding pending APB commands.
//   i_clk    : clock, rising edge
//   i_rst    : synchronous active-high reset, flushes the buffer
//   i_push   : write i_wdata (ignored while full)
//   i_wdata  : entry to store
//   i_pop    : drop the head entry (ignored while empty)
//   o_rdata  : head entry, valid combinationally whenever !o_empty
//   o_full   : no free entry
//   o_empty  : no stored entry
module apb2_cmd_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam logic [PTR_BITS:0] PTR_ONE = {{PTR_BITS{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_BITS:0] r_wr_ptr;
  logic [PTR_BITS:0] r_rd_ptr;
  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PTR_BITS] != r_rd_ptr[PTR_BITS]) &&
                     (r_wr_ptr[PTR_BITS-1:0] == r_rd_ptr[PTR_BITS-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr[PTR_BITS-1:0]];

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[PTR_BITS-1:0]] <= i_wdata;
    end
  end

  // Read/write pointer update with synchronous flush.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= {(PTR_BITS+1){1'b0}};
      r_rd_ptr <= {(PTR_BITS+1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/apb2_master.sv
// apb2_master
// APB2 initiator: buffers commands, runs each as a fixed SETUP+ACCESS transfer
// and reports completion with a one-cycle response pulse.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset; aborts any transfer and flushes the buffer
//   bus  : apb2_master_if.master -- command port, response port and APB2 bus
//   busy : a transfer is running, commands are queued, or a response is being reported
module apb2_master
  import apb2_master_pkg::*;
#(
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  apb2_master_if.master bus,
  output logic          busy
);

  localparam int ENTRY_BITS = cmd_entry_bits(ADDR_BITS, DATA_BITS);

  apb_state_e r_state;
  apb_state_e w_next_state;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [ENTRY_BITS-1:0] w_push_entry;
  logic [ENTRY_BITS-1:0] w_head_entry;
  logic                  w_head_write;
  logic [ADDR_BITS-1:0]  w_head_addr;
  logic [DATA_BITS-1:0]  w_head_wdata;

  logic [ADDR_BITS-1:0]  r_paddr;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [DATA_BITS-1:0]  r_pwdata;
  logic                  r_rsp_valid;
  logic                  r_rsp_write;
  logic [DATA_BITS-1:0]  r_rsp_rdata;

  // cmd_ready follows the registered full flag only, so a pop in the same
  // cycle cannot reopen the port.
  assign bus.cmd_ready = !w_full;
  assign w_push        = bus.cmd_valid && !w_full;
  assign w_push_entry  = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};

  assign w_head_write  = w_head_entry[ENTRY_BITS-1];
  assign w_head_addr   = w_head_entry[DATA_BITS +: ADDR_BITS];
  assign w_head_wdata  = w_head_entry[DATA_BITS-1:0];

  apb2_cmd_fifo #(
    .WIDTH (ENTRY_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_wdata (w_push_entry),
    .i_pop   (w_pop),
    .o_rdata (w_head_entry),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Next transfer phase and head-pop decision.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_next_state = ST_SETUP;
          w_pop        = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SETUP: begin
        w_next_state = ST_ACCESS;
      end
      ST_ACCESS: begin
        // Queued work chains straight into the next SETUP with PSEL held high.
        if (!w_empty) begin
          w_next_state = ST_SETUP;
          w_pop        = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Transfer phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // APB request registers; address/direction/data load only when a command starts,
  // so they stay stable through ACCESS and hold while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_paddr   <= {ADDR_BITS{1'b0}};
      r_pwrite  <= 1'b0;
      r_pwdata  <= {DATA_BITS{1'b0}};
    end else begin
      r_psel    <= (w_next_state != ST_IDLE);
      r_penable <= (w_next_state == ST_ACCESS);
      if (w_pop) begin
        r_paddr  <= w_head_addr;
        r_pwrite <= w_head_write;
        r_pwdata <= w_head_wdata;
      end
    end
  end

  // Response registers, loaded on the edge that ends ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= {DATA_BITS{1'b0}};
    end else begin
      r_rsp_valid <= (r_state == ST_ACCESS);
      if (r_state == ST_ACCESS) begin
        r_rsp_write <= r_pwrite;
        r_rsp_rdata <= r_pwrite ? {DATA_BITS{1'b0}} : bus.PRDATA;
      end
    end
  end

  assign bus.PADDR     = r_paddr;
  assign bus.PSEL      = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PWDATA    = r_pwdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_write = r_rsp_write;
  assign bus.rsp_rdata = r_rsp_rdata;

  assign busy = (r_state != ST_IDLE) || !w_empty || r_rsp_valid;

endmodule

// File: tb/tb_apb2_master.sv
// tb_apb2_master
// Drives apb2_master against a behavioural APB2 memory target (8 RW bytes at 0..7,
// 8 RO bytes at 8..15, zero elsewhere) and checks responses against an in-order
// expected-response queue computed from a byte-array memory model.
module tb_apb2_master;

  localparam int AB    = 6;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int HIST  = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  apb2_master_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus_if();

  apb2_master #(
    .ADDR_BITS  (AB),
    .DATA_BITS  (DB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_if),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // ---------------- APB2 memory target ----------------
  logic [63:0] mem_rw_values = 64'h0;
  logic [63:0] mem_ro_values = 64'h0;

  always @(posedge clk) begin
    if (!rst && bus_if.PSEL && bus_if.PENABLE && bus_if.PWRITE && (bus_if.PADDR < 6'd8))
      mem_rw_values[int'(bus_if.PADDR[2:0])*8 +: 8] <= bus_if.PWDATA;
  end

  always_comb begin
    bus_if.PRDATA = 8'h00;
    if (bus_if.PSEL && !bus_if.PWRITE) begin
      if (bus_if.PADDR < 6'd8)
        bus_if.PRDATA = mem_rw_values[int'(bus_if.PADDR[2:0])*8 +: 8];
      else if (bus_if.PADDR < 6'd16)
        bus_if.PRDATA = mem_ro_values[int'(bus_if.PADDR[2:0])*8 +: 8];
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       write;
    logic [7:0] rdata;
  } rsp_t;

  logic [7:0] model_rw [8];
  logic [7:0] model_save [8];
  rsp_t       exp_q [$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rsp_seen = 0;
  int accepted = 0;
  int full_at = -1;
  int fill_acc = 0;

  bit psel_h [HIST];
  bit pen_h  [HIST];
  bit rsp_h  [HIST];

  logic        prev_setup = 1'b0;
  logic [63:0] prev_bus = 64'h0;
  logic        last_rsp_write = 1'b0;
  logic [7:0]  last_rsp_rdata = 8'h00;

  function automatic logic [7:0] model_read(input logic [5:0] a);
    if (a < 6'd8)       return model_rw[a[2:0]];
    else if (a < 6'd16) return mem_ro_values[int'(a[2:0])*8 +: 8];
    else                return 8'h00;
  endfunction

  function automatic logic [63:0] model_pack();
    logic [63:0] r;
    r = 64'h0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = model_rw[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance past the edge, then run protocol and scoreboard checks.
  task automatic step();
    logic rst_edge;
    rst_edge = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < HIST) begin
      psel_h[cyc] = bus_if.PSEL;
      pen_h[cyc]  = bus_if.PENABLE;
      rsp_h[cyc]  = bus_if.rsp_valid;
    end
    chk("penable_without_psel", 64'(bus_if.PENABLE && !bus_if.PSEL), 64'd0);
    if (prev_setup && !rst_edge) begin
      chk("access_follows_setup", {62'd0, bus_if.PSEL, bus_if.PENABLE}, 64'd3);
      chk("bus_stable_setup_access", {49'd0, bus_if.PADDR, bus_if.PWRITE, bus_if.PWDATA}, prev_bus);
    end
    prev_setup = bus_if.PSEL && !bus_if.PENABLE;
    prev_bus   = {49'd0, bus_if.PADDR, bus_if.PWRITE, bus_if.PWDATA};
    if (bus_if.rsp_valid) begin
      rsp_t e;
      chk("rsp_expected", 64'(exp_q.size() != 0), 64'(bus_if.rsp_valid));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_write", 64'(bus_if.rsp_write), 64'(e.write));
        chk("rsp_rdata", 64'(bus_if.rsp_rdata), 64'(e.rdata));
      end
      rsp_seen++;
      last_rsp_write = bus_if.rsp_write;
      last_rsp_rdata = bus_if.rsp_rdata;
    end
  endtask

  // Offer a command until accepted (bounded), updating the model on acceptance.
  task automatic send(input bit w, input logic [5:0] a, input logic [7:0] d);
    bit acc;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_write = w;
    bus_if.cmd_addr  = a;
    bus_if.cmd_wdata = d;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      acc = bus_if.cmd_ready;
      if (acc) begin
        if (w) begin
          if (a < 6'd8) model_rw[a[2:0]] = d;
          exp_q.push_back('{write: 1'b1, rdata: 8'h00});
        end else begin
          exp_q.push_back('{write: 1'b0, rdata: model_read(a)});
        end
        accepted++;
        fill_acc++;
      end
      step();
      if (acc && !bus_if.cmd_ready && full_at < 0) full_at = fill_acc;
    end
    if (!acc) chk("accept_timeout", 64'(bus_if.cmd_ready), 64'd1);
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!busy && exp_q.size() == 0) break;
      step();
    end
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_pending_rsp", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int rsp_start;
    int acc_start;
    logic [63:0] mem_before;

    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_write = 1'b0;
    bus_if.cmd_addr  = 6'd0;
    bus_if.cmd_wdata = 8'd0;
    mem_ro_values = {$urandom(), $urandom()};
    for (int i = 0; i < 8; i++) model_rw[i] = 8'h00;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_psel_penable", {62'd0, bus_if.PSEL, bus_if.PENABLE}, 64'd0);
    chk("rst_bus_regs", {49'd0, bus_if.PADDR, bus_if.PWRITE, bus_if.PWDATA}, 64'd0);
    chk("rst_rsp", {55'd0, bus_if.rsp_valid, bus_if.rsp_write, bus_if.rsp_rdata}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    step();
    chk("cmd_ready_after_rst", 64'(bus_if.cmd_ready), 64'd1);

    // 1) write then read back the same RW byte
    send(1'b1, 6'd3, 8'hA5);
    send(1'b0, 6'd3, 8'h00);
    wait_idle();
    chk("t1_read_write_flag", 64'(last_rsp_write), 64'd0);
    chk("t1_read_data", 64'(last_rsp_rdata), 64'hA5);
    chk("t1_mem_byte3", 64'(mem_rw_values[31:24]), 64'hA5);

    // 2) read-only region and unmapped region
    for (int a = 8; a < 24; a++) send(1'b0, 6'(a), 8'h00);
    wait_idle();

    // 3) four back-to-back writes: contiguous PSEL, PENABLE toggling, rsp every 2 cycles
    a0 = cyc + 1;
    send(1'b1, 6'd0, 8'($urandom()));
    send(1'b1, 6'd1, 8'($urandom()));
    send(1'b1, 6'd2, 8'($urandom()));
    send(1'b1, 6'd7, 8'($urandom()));
    wait_idle();
    for (int j = 1; j <= 8; j++) begin
      chk($sformatf("t3_psel_%0d", j), 64'(psel_h[a0+j]), 64'd1);
      chk($sformatf("t3_penable_%0d", j), 64'(pen_h[a0+j]), 64'((j % 2) == 0));
    end
    chk("t3_psel_drop", 64'(psel_h[a0+9]), 64'd0);
    for (int k = 3; k <= 10; k++)
      chk($sformatf("t3_rsp_%0d", k), 64'(rsp_h[a0+k]), 64'((k % 2) == 1));
    chk("t3_mem", mem_rw_values, model_pack());

    // Buffer fill: continuous offers from idle fill 1/cycle and drain 1 per 2 cycles,
    // so the buffer first reports full right after the 7th acceptance.
    full_at  = -1;
    fill_acc = 0;
    for (int i = 0; i < 8; i++) send(1'b1, 6'(i), 8'($urandom()));
    wait_idle();
    chk("fill_full_after_accept", 64'(full_at), 64'd7);
    chk("fill_mem", mem_rw_values, model_pack());

    // 4) single read on an idle bus: latency
    send(1'b0, 6'd9, 8'h00);
    chk("t4_psel_at_accept", 64'(bus_if.PSEL), 64'd0);
    step();
    chk("t4_setup", {62'd0, bus_if.PSEL, bus_if.PENABLE}, 64'd2);
    step();
    chk("t4_access", {62'd0, bus_if.PSEL, bus_if.PENABLE}, 64'd3);
    chk("t4_no_rsp_yet", 64'(bus_if.rsp_valid), 64'd0);
    step();
    chk("t4_rsp_at_3", 64'(bus_if.rsp_valid), 64'd1);
    wait_idle();

    // 5) reset during ACCESS with two commands still queued
    model_save = model_rw;
    mem_before = mem_rw_values;
    send(1'b1, 6'd4, 8'h11);
    send(1'b1, 6'd5, 8'h22);
    send(1'b1, 6'd6, 8'h33);
    chk("t5_in_access", {62'd0, bus_if.PSEL, bus_if.PENABLE}, 64'd3);
    chk("t5_queued_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    chk("t5_psel_penable", {62'd0, bus_if.PSEL, bus_if.PENABLE}, 64'd0);
    chk("t5_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    model_rw = model_save;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t5_no_transfer", {62'd0, bus_if.PSEL, bus_if.rsp_valid}, 64'd0);
    end
    chk("t5_mem_unchanged", mem_rw_values, mem_before);

    // 6) random mix with random gaps
    rsp_start = rsp_seen;
    acc_start = accepted;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) step();
      send(1'($urandom_range(0, 1)), 6'($urandom_range(0, 23)), 8'($urandom()));
    end
    wait_idle();
    chk("t6_one_rsp_per_cmd", 64'(rsp_seen - rsp_start), 64'(accepted - acc_start));
    chk("t6_mem", mem_rw_values, model_pack());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
